// File: rtl/sawtooth_wave.sv
// sawtooth_wave
// Phase-accumulator sawtooth generator. Every clock the 8-bit frequency word
// is added to a free-running phase accumulator. The top eight accumulator bits
// form an unsigned ramp sample for the mixer/DAC path. Wrap-around is silent:
// the carry out of the accumulator is dropped, so the ramp falls straight from
// its peak to a low value in one clock.
module sawtooth_wave #(
   parameter int ACC_WIDTH = 12
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] frequency_control,
   output logic [7:0] sawtooth_out
);

   // Sample width is fixed by the downstream DAC path and is not a parameter.
   localparam int OUT_WIDTH = 8;

   // Phase register and its next value.
   logic [ACC_WIDTH-1:0] acc;
   logic [ACC_WIDTH-1:0] acc_next;

   // Modular phase step. The increment is zero-extended to the accumulator
   // width, and the sum is truncated to ACC_WIDTH bits, which discards the
   // carry and gives the silent wrap.
   function automatic logic [ACC_WIDTH-1:0] phase_step(
      input logic [ACC_WIDTH-1:0] phase,
      input logic [7:0]           increment
   );
      logic [ACC_WIDTH-1:0] inc_ext;
      inc_ext = ACC_WIDTH'(increment);
      return phase + inc_ext;
   endfunction

   // Next phase: always advance by the current increment. An increment of
   // zero holds the phase, which gives a DC output.
   always_comb begin
      acc_next = acc;
      acc_next = phase_step(acc, frequency_control);
   end

   // Phase register. Asynchronous reset clears the ramp immediately. A new
   // increment takes effect from the next edge with no phase discontinuity.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= {ACC_WIDTH{1'b0}};
      end else begin
         acc <= acc_next;
      end
   end

   // The sample comes directly from the register's top bits, with no logic
   // after the flops.
   assign sawtooth_out = acc[ACC_WIDTH-1 -: OUT_WIDTH];

endmodule

// File: tb/tb_sawtooth_wave.sv
// Testbench for sawtooth_wave (default ACC_WIDTH = 12).
// The stimulus side drives inputs on the falling clock edge and pushes the
// sample expected after the following rising edge into a queue. An
// independent monitor pops one entry per rising edge and compares it.
module tb_sawtooth_wave;

   logic       clk;
   logic       rst_n;
   logic [7:0] frequency_control;
   logic [7:0] sawtooth_out;

   typedef struct {
      int    exp;
      string tag;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks;
   int   n_fail;

   sawtooth_wave #(.ACC_WIDTH(12)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .frequency_control (frequency_control),
      .sawtooth_out      (sawtooth_out)
   );

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point; every check funnels through here
   task automatic check(input string tag, input int act, input int exp);
      n_checks = n_checks + 1;
      if (act !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got %0d, expected %0d at %0t", tag, act, exp, $time);
      end
   endtask

   // Drive one cycle on the falling edge and queue the sample expected after
   // the next rising edge
   task automatic drive(input logic r, input logic [7:0] fc, input int exp, input string tag);
      exp_t e;
      @(negedge clk);
      rst_n             = r;
      frequency_control = fc;
      e.exp = exp;
      e.tag = tag;
      exp_q.push_back(e);
   endtask

   // Monitor: one output sample per rising edge, checked 2 ns after the edge
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check(e.tag, int'(sawtooth_out), e.exp);
         end
      end
   end

   // Watchdog
   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "simulation time limit reached");
   end

   // Stimulus
   initial begin
      int acc_m;
      int fc_r;
      n_checks          = 0;
      n_fail            = 0;
      rst_n             = 1'b0;
      frequency_control = 8'd32;

      // Reset held with a non-zero increment: output stays 0
      #1;
      check("reset_t0", int'(sawtooth_out), 0);
      for (int i = 0; i < 5; i++) drive(1'b0, 8'd32, 0, "reset_hold");

      // Basic ramp at 32: edge N gives 2N mod 256
      for (int n = 1; n <= 130; n++) begin
         case (n)
            1:       drive(1'b1, 8'd32, 2,   "ramp_edge1");
            50:      drive(1'b1, 8'd32, 100, "ramp_edge50");
            127:     drive(1'b1, 8'd32, 254, "ramp_edge127");
            128:     drive(1'b1, 8'd32, 0,   "ramp_wrap128");
            129:     drive(1'b1, 8'd32, 2,   "ramp_edge129");
            default: drive(1'b1, 8'd32, (2 * n) % 256, "ramp");
         endcase
      end

      // Asynchronous reset mid-ramp at output 40
      drive(1'b0, 8'd32, 0, "rst_before_async");
      for (int n = 1; n <= 20; n++) drive(1'b1, 8'd32, 2 * n, "async_ramp");
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("async_reset", int'(sawtooth_out), 0);
      drive(1'b0, 8'd32, 0, "async_reset_hold");

      // Zero increment: 10 edges at 32 (output 20), then hold for 50 edges
      for (int n = 1; n <= 10; n++) drive(1'b1, 8'd32, 2 * n, "zero_pre");
      for (int n = 0; n < 50; n++) drive(1'b1, 8'd0, 20, "zero_hold");

      // Maximum increment 255: 15, ..., 255 (acc 4080), then 14 (acc 239)
      drive(1'b0, 8'd0, 0, "rst_before_max");
      for (int n = 1; n <= 17; n++) begin
         case (n)
            1:       drive(1'b1, 8'd255, 15,  "max_edge1");
            16:      drive(1'b1, 8'd255, 255, "max_edge16");
            17:      drive(1'b1, 8'd255, 14,  "max_edge17");
            default: drive(1'b1, 8'd255, ((255 * n) % 4096) / 16, "max_ramp");
         endcase
      end

      // Wrap example: acc 4080 reached with 255, then +32 gives acc 16, output 1
      drive(1'b0, 8'd0, 0, "rst_before_wrap");
      for (int n = 1; n <= 16; n++) drive(1'b1, 8'd255, ((255 * n) % 4096) / 16, "wrap_pre");
      drive(1'b1, 8'd32, 1, "wrap_4080_plus_32");

      // Frequency change: 20 edges at 32 (output 40), then 64: 44, 48, 52 ...
      drive(1'b0, 8'd0, 0, "rst_before_fchg");
      for (int n = 1; n <= 20; n++) drive(1'b1, 8'd32, 2 * n, "fchg_pre");
      for (int k = 1; k <= 60; k++) begin
         case (k)
            1:       drive(1'b1, 8'd64, 44,  "fchg_k1");
            2:       drive(1'b1, 8'd64, 48,  "fchg_k2");
            3:       drive(1'b1, 8'd64, 52,  "fchg_k3");
            53:      drive(1'b1, 8'd64, 252, "fchg_peak");
            54:      drive(1'b1, 8'd64, 0,   "fchg_wrap");
            default: drive(1'b1, 8'd64, ((640 + 64 * k) % 4096) / 16, "fchg");
         endcase
      end

      // Randomised run against a reference accumulator, with occasional resets
      drive(1'b0, 8'd0, 0, "rst_before_rand");
      acc_m = 0;
      fc_r  = 0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 15) == 0) fc_r = int'($urandom_range(0, 255));
         if ($urandom_range(0, 99) == 0) begin
            acc_m = 0;
            drive(1'b0, 8'(fc_r), 0, "rand_reset");
         end else begin
            acc_m = (acc_m + fc_r) % 4096;
            drive(1'b1, 8'(fc_r), acc_m / 16, "rand");
         end
      end

      // Let the monitor drain, then confirm nothing was left unchecked
      repeat (3) @(negedge clk);
      check("queue_drain", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
